// File: rtl/azimuth_pattern_sequencer_if.sv
// Pattern sequencer control/data bundle: the master drives the controls and
// the patterns, and the sequencer (slave) returns the serial outputs and status.
interface azimuth_pattern_sequencer_if #(
    parameter int SIZE     = 3200,
    parameter int CHANNELS = 4
);
    localparam int IW = $clog2(SIZE);

    logic                     EN;
    logic                     TRIG;
    logic                     MODE;
    logic                     LOAD;
    logic [CHANNELS*SIZE-1:0] DATA;
    logic [CHANNELS-1:0]      SIGNAL;
    logic                     BUSY;
    logic                     DONE;
    logic [IW-1:0]            INDEX;

    modport master (
        output EN, TRIG, MODE, LOAD, DATA,
        input  SIGNAL, BUSY, DONE, INDEX
    );

    modport slave (
        input  EN, TRIG, MODE, LOAD, DATA,
        output SIGNAL, BUSY, DONE, INDEX
    );
endinterface

// File: rtl/azimuth_pattern_sequencer.sv
// Multi-channel serial pattern sequencer: on a TRIG rising edge it shifts out a
// latched SIZE-bit pattern per channel, LSB first, holding each bit DIV cycles.
module azimuth_pattern_sequencer #(
    parameter int SIZE     = 3200,
    parameter int CHANNELS = 4,
    parameter int DIV      = 1
) (
    input  logic CLK,
    input  logic RESETN,
    azimuth_pattern_sequencer_if.slave bus
);
    localparam int IW = $clog2(SIZE);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(SIZE - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e                             state_q;
    logic [CHANNELS-1:0][SIZE-1:0]      shadow_q;
    logic [CHANNELS-1:0][SIZE-1:0]      active_q;
    logic [CHANNELS-1:0][SIZE-1:0]      pattern_d;
    logic [IW-1:0]                      idx_q;
    logic [IW-1:0]                      idx_d;
    logic [PW-1:0]                      pre_q;
    logic                               trig_q;
    logic                               arm_q;
    logic [CHANNELS-1:0]                sig_q;
    logic                               done_q;
    logic [CHANNELS-1:0]                first_bits;
    logic [CHANNELS-1:0]                step_bits;
    logic                               trig_edge;

    // Same-edge LOAD bypasses the shadow so a new pattern can start immediately.
    assign pattern_d = bus.LOAD ? bus.DATA : shadow_q;
    assign idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    // arm_q blocks a TRIG that was already high when reset was released.
    assign trig_edge = bus.TRIG & ~trig_q & arm_q;

    always_comb begin
        first_bits = '0;
        step_bits  = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            first_bits[c] = pattern_d[c][0];
            step_bits[c]  = active_q[c][idx_d];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            active_q <= '0;
            idx_q    <= '0;
            pre_q    <= '0;
            trig_q   <= 1'b0;
            arm_q    <= ~bus.TRIG;
            sig_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            trig_q <= bus.TRIG;
            done_q <= 1'b0;
            if (!bus.TRIG) begin
                arm_q <= 1'b1;
            end
            if (bus.LOAD) begin
                shadow_q <= bus.DATA;
            end

            if (!bus.EN) begin
                state_q <= IDLE;
                sig_q   <= '0;
                idx_q   <= '0;
                pre_q   <= '0;
            end else if (trig_edge) begin
                state_q  <= RUN;
                active_q <= pattern_d;
                idx_q    <= '0;
                pre_q    <= '0;
                sig_q    <= first_bits;
            end else if (state_q == RUN) begin
                if (pre_q == PRE_LAST) begin
                    pre_q <= '0;
                    if (idx_q == IDX_LAST) begin
                        done_q <= 1'b1;
                        idx_q  <= '0;
                        if (bus.MODE) begin
                            active_q <= pattern_d;
                            sig_q    <= first_bits;
                        end else begin
                            state_q <= IDLE;
                            sig_q   <= '0;
                        end
                    end else begin
                        idx_q <= idx_d;
                        sig_q <= step_bits;
                    end
                end else begin
                    pre_q <= pre_q + 1'b1;
                end
            end
        end
    end

    assign bus.SIGNAL = sig_q;
    assign bus.BUSY   = (state_q == RUN);
    assign bus.DONE   = done_q;
    assign bus.INDEX  = idx_q;
endmodule

// File: tb/tb_azimuth_pattern_sequencer.sv
// Scoreboard bench: each driven cycle queues the outputs expected after the next
// rising edge; a monitor pops and compares them once per cycle.
module tb_azimuth_pattern_sequencer;
    localparam int S  = 8;
    localparam int C  = 2;
    localparam int D  = 2;
    localparam int BS = 3200;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic CLK = 1'b0;
    logic RESETN;
    logic rst_n_drv;

    exp_t        sb[$];
    exp_t        sbb[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 CLK = ~CLK;

    azimuth_pattern_sequencer_if #(.SIZE(S), .CHANNELS(C)) bus ();
    azimuth_pattern_sequencer_if #(.SIZE(BS), .CHANNELS(1)) bbus ();

    azimuth_pattern_sequencer #(.SIZE(S), .CHANNELS(C), .DIV(D)) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .bus    (bus)
    );

    azimuth_pattern_sequencer #(.SIZE(BS), .CHANNELS(1), .DIV(1)) dut_big (
        .CLK    (CLK),
        .RESETN (RESETN),
        .bus    (bbus)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk(logic [1:0] sig, logic busy, logic done, logic [2:0] idx);
        return {25'b0, idx, done, busy, sig};
    endfunction

    function automatic logic [31:0] pkb(logic sig, logic busy, logic done, logic [11:0] idx);
        return {17'b0, idx, done, busy, sig};
    endfunction

    // Expected outputs k cycles after a sweep start: bit k/DIV of each channel.
    function automatic logic [31:0] swp(logic [15:0] pat, int k, logic dn);
        int i;
        i = k / D;
        return pk({pat[S+i], pat[i]}, 1'b1, dn, 3'(i));
    endfunction

    task automatic step(input logic en, input logic trig, input logic mode, input logic load,
                        input logic [15:0] data, input string tag, input logic [31:0] e);
        @(negedge CLK);
        RESETN   = rst_n_drv;
        bus.EN   = en;
        bus.TRIG = trig;
        bus.MODE = mode;
        bus.LOAD = load;
        bus.DATA = data;
        sb.push_back('{tag, e});
    endtask

    task automatic stepb(input logic en, input logic trig, input logic load,
                         input logic [BS-1:0] data, input string tag, input logic [31:0] e);
        @(negedge CLK);
        RESETN    = rst_n_drv;
        bbus.EN   = en;
        bbus.TRIG = trig;
        bbus.MODE = 1'b0;
        bbus.LOAD = load;
        bbus.DATA = data;
        sbb.push_back('{tag, e});
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_eq(e.tag, {25'b0, bus.INDEX, bus.DONE, bus.BUSY, bus.SIGNAL}, e.val);
            end
            if (sbb.size() > 0) begin
                e = sbb.pop_front();
                check_eq(e.tag, {17'b0, bbus.INDEX, bbus.DONE, bbus.BUSY, bbus.SIGNAL}, e.val);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [BS-1:0] bd;
        rst_n_drv = 1'b0;
        RESETN    = 1'b0;
        bus.EN = 1'b0; bus.TRIG = 1'b0; bus.MODE = 1'b0; bus.LOAD = 1'b0; bus.DATA = '0;
        bbus.EN = 1'b0; bbus.TRIG = 1'b0; bbus.MODE = 1'b0; bbus.LOAD = 1'b0; bbus.DATA = '0;

        step(1, 0, 0, 1, 16'hFFFF, "rst0", pk(0, 0, 0, 0));
        step(1, 0, 0, 0, 16'h0000, "rst1", pk(0, 0, 0, 0));
        rst_n_drv = 1'b1;

        // One-shot sweep of A50F
        step(1, 0, 0, 1, 16'hA50F, "t1 load", pk(0, 0, 0, 0));
        step(1, 1, 0, 0, 16'h0000, "t1 k0", swp(16'hA50F, 0, 0));
        for (int k = 1; k < 16; k++)
            step(1, 1, 0, 0, 16'h0000, $sformatf("t1 k%0d", k), swp(16'hA50F, k, 0));
        step(1, 0, 0, 0, 16'h0000, "t1 done", pk(0, 0, 1, 0));
        step(1, 0, 0, 0, 16'h0000, "t1 idle", pk(0, 0, 0, 0));

        // Continuous: mid-sweep LOAD only affects the next sweep; MODE glitch ignored
        step(1, 0, 1, 1, 16'h00FF, "t2 load", pk(0, 0, 0, 0));
        step(1, 1, 1, 0, 16'h0000, "t2 a0", swp(16'h00FF, 0, 0));
        for (int k = 1; k < 16; k++)
            step(1, 0, (k != 8), (k == 5), (k == 5) ? 16'hFF00 : 16'h0000,
                 $sformatf("t2 a%0d", k), swp(16'h00FF, k, 0));
        for (int k = 0; k < 16; k++)
            step(1, 0, 1, 0, 16'h0000, $sformatf("t2 b%0d", k), swp(16'hFF00, k, (k == 0)));
        step(1, 0, 1, 1, 16'h0F0F, "t2 c0", swp(16'h0F0F, 0, 1));
        for (int k = 1; k < 16; k++)
            step(1, 0, (k < 3), 0, 16'h0000, $sformatf("t2 c%0d", k), swp(16'h0F0F, k, 0));
        step(1, 0, 0, 0, 16'h0000, "t2 done", pk(0, 0, 1, 0));

        // Restart at INDEX=5, then a restart coinciding with end of sweep
        step(1, 1, 0, 0, 16'h0000, "t3 a0", swp(16'h0F0F, 0, 0));
        for (int k = 1; k <= 10; k++)
            step(1, 0, 0, 0, 16'h0000, $sformatf("t3 a%0d", k), swp(16'h0F0F, k, 0));
        step(1, 1, 0, 0, 16'h0000, "t3 b0", swp(16'h0F0F, 0, 0));
        for (int k = 1; k < 16; k++)
            step(1, 0, 0, 0, 16'h0000, $sformatf("t3 b%0d", k), swp(16'h0F0F, k, 0));
        step(1, 1, 0, 0, 16'h0000, "t3 c0", swp(16'h0F0F, 0, 0));
        for (int k = 1; k < 16; k++)
            step(1, 0, 0, 0, 16'h0000, $sformatf("t3 c%0d", k), swp(16'h0F0F, k, 0));
        step(1, 0, 0, 0, 16'h0000, "t3 done", pk(0, 0, 1, 0));
        step(1, 0, 0, 0, 16'h0000, "t3 idle", pk(0, 0, 0, 0));

        // EN drop at INDEX=3; triggers while disabled ignored, LOAD still captured
        step(1, 1, 0, 1, 16'hA50F, "t4 a0", swp(16'hA50F, 0, 0));
        for (int k = 1; k <= 6; k++)
            step(1, 0, 0, 0, 16'h0000, $sformatf("t4 a%0d", k), swp(16'hA50F, k, 0));
        step(0, 0, 0, 0, 16'h0000, "t4 off", pk(0, 0, 0, 0));
        step(0, 1, 0, 0, 16'h0000, "t4 dis0", pk(0, 0, 0, 0));
        step(0, 0, 0, 1, 16'hFF00, "t4 dis1", pk(0, 0, 0, 0));
        step(0, 1, 0, 0, 16'h0000, "t4 dis2", pk(0, 0, 0, 0));
        step(1, 1, 0, 0, 16'h0000, "t4 nomem", pk(0, 0, 0, 0));
        step(1, 0, 0, 0, 16'h0000, "t4 low", pk(0, 0, 0, 0));
        step(1, 1, 0, 0, 16'h0000, "t4 b0", swp(16'hFF00, 0, 0));
        for (int k = 1; k <= 12; k++)
            step(1, 0, 0, 0, 16'h0000, $sformatf("t4 b%0d", k), swp(16'hFF00, k, 0));

        // Reset mid-sweep at INDEX=6 clears the shadow too
        rst_n_drv = 1'b0;
        step(1, 0, 0, 0, 16'h0000, "t5 rst", pk(0, 0, 0, 0));
        rst_n_drv = 1'b1;
        step(1, 1, 0, 0, 16'h0000, "t5 k0", swp(16'h0000, 0, 0));
        for (int k = 1; k < 16; k++)
            step(1, 0, 0, 0, 16'h0000, $sformatf("t5 k%0d", k), swp(16'h0000, k, 0));
        step(1, 0, 0, 0, 16'h0000, "t5 done", pk(0, 0, 1, 0));

        // TRIG held high through reset release must not start a sweep
        rst_n_drv = 1'b0;
        step(1, 1, 0, 0, 16'h0000, "t6 rst", pk(0, 0, 0, 0));
        rst_n_drv = 1'b1;
        step(1, 1, 0, 0, 16'h0000, "t6 hold0", pk(0, 0, 0, 0));
        step(1, 1, 0, 0, 16'h0000, "t6 hold1", pk(0, 0, 0, 0));
        step(1, 0, 0, 0, 16'h0000, "t6 low", pk(0, 0, 0, 0));
        step(1, 1, 0, 0, 16'h0000, "t6 go", swp(16'h0000, 0, 0));
        step(0, 0, 0, 0, 16'h0000, "t6 off", pk(0, 0, 0, 0));

        // Full-size single channel, DIV=1: half-high pattern, then its complement
        bd = '0;
        bd[BS/2-1:0] = '1;
        for (int r = 0; r < 2; r++) begin
            stepb(1, 0, 1, (r == 0) ? bd : ~bd, $sformatf("b%0d load", r), pkb(0, 0, 0, 0));
            for (int k = 0; k < BS; k++)
                stepb(1, (k == 0), 0, '0, $sformatf("b%0d k%0d", r, k),
                      pkb(((k < BS/2) ? 1'b1 : 1'b0) ^ r[0], 1'b1, 1'b0, 12'(k)));
            stepb(1, 0, 0, '0, $sformatf("b%0d done", r), pkb(0, 0, 1, 0));
            stepb(1, 0, 0, '0, $sformatf("b%0d idle", r), pkb(0, 0, 0, 0));
        end

        repeat (3) @(negedge CLK);
        check_eq("drain", 32'(sb.size() + sbb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
